mult_div_unit: RTL and testbench
================================

MULT_DIV_UNIT -- requirements
Module: mult_div_unit

Interface
REQ-001 The block SHALL have one parameter: ITER, default 32, number of iteration cycles per operation.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-004 start  input  1  request new operation; sampled on rising edge.
REQ-005 op  input  2  00 MULTU, 01 MULT, 10 DIVU, 11 DIV.
REQ-006 rsdata  input  32  operand A (multiplicand/dividend), from register-file read port.
REQ-007 rtdata  input  32  operand B (multiplier/divisor), from register-file read port.
REQ-008 mthi  input  1  write writedata into HI.
REQ-009 mtlo  input  1  write writedata into LO.
REQ-010 writedata  input  32  data for mthi/mtlo.
REQ-011 busy  output  1  operation in progress.
REQ-012 done  output  1  one-cycle pulse: HI/LO just updated with a result.
REQ-013 hi  output  32  HI register (product[63:32] / remainder).
REQ-014 lo  output  32  LO register (product[31:0] / quotient).

Function
REQ-015 FSM states SHALL be IDLE, RUN, FIX; IDLE->RUN on start in IDLE; RUN->FIX after ITER iteration edges; FIX->IDLE unconditionally.
REQ-016 On accepting start, the block SHALL latch op and the operands; for MULT/DIV it SHALL latch absolute values and record result signs.
REQ-017 MULTU/MULT SHALL use iterative shift-add, one multiplier bit per RUN cycle, 64-bit unsigned accumulator.
REQ-018 DIVU/DIV SHALL use iterative restoring division, one quotient bit per RUN cycle.
REQ-019 In FIX, the block SHALL apply sign correction and load hi/lo: MULT product negated if sign(A) xor sign(B); DIV quotient negated if sign(A) xor sign(B), remainder negated if sign(A).
REQ-020 Latency: start sampled at edge N -> busy=1 after edges N..N+ITER (ITER+1 cycles); hi/lo updated, done=1 and busy=0 after edge N+ITER+1.
REQ-021 done SHALL be high exactly one cycle per completed operation and never otherwise.
REQ-022 hi/lo SHALL hold previous values during RUN; internal accumulators are separate registers.
REQ-023 start while busy SHALL be ignored; no queueing.
REQ-024 mthi/mtlo SHALL take effect at the next edge only when not busy and start is low; mthi/mtlo while busy, or coinciding with start, SHALL be ignored.
REQ-025 mthi and mtlo together SHALL write writedata into both hi and lo.
REQ-026 Divide by zero (B=0, DIVU or DIV) SHALL complete with normal latency and give lo=32'hFFFFFFFF, hi=rsdata unmodified.
REQ-027 DIV 0x80000000 / 0xFFFFFFFF SHALL give lo=0x80000000, hi=0x00000000; no exception signal.
REQ-028 Operands on rsdata/rtdata SHALL be don't-care after the start edge.
REQ-029 A new start in the same cycle done is high SHALL be accepted (back-to-back, IDLE reached).

Reset
REQ-030 rst_n low SHALL immediately force state IDLE, busy=0, done=0, hi=0, lo=0, accumulators cleared.
REQ-031 Reset mid-operation SHALL abort it; no done pulse; hi/lo remain 0 after release.
REQ-032 The first start SHALL be accepted on the first rising edge with rst_n high.

Verification
REQ-033 MULTU 0xFFFFFFFF x 0xFFFFFFFF at edge N -> hi=0xFFFFFFFE, lo=0x00000001, done high only after edge N+33.
REQ-034 MULT 0xFFFFFFFD(-3) x 0x00000005 -> hi=0xFFFFFFFF, lo=0xFFFFFFF1.
REQ-035 DIV 0xFFFFFFF9(-7) / 0x00000002 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF; DIVU 5/0 -> lo=0xFFFFFFFF, hi=0x00000005.
REQ-036 DIV 0x80000000 / 0xFFFFFFFF -> lo=0x80000000, hi=0x00000000.
REQ-037 mthi 0x12345678 in IDLE -> hi=0x12345678 next cycle; mtlo and a second start during busy -> both ignored, lo and result unaffected.
REQ-038 rst_n low 10 cycles into a DIV -> busy=0, hi=lo=0 immediately, no done; new MULTU 2x3 after release -> lo=6, hi=0.

Source files
------------

// File: rtl/mult_div_unit.sv
// Iterative HI/LO multiply/divide unit: shift-add multiply and restoring divide,
// one result bit per cycle, with sign fix-up in a final cycle before HI/LO load.
module mult_div_unit #(
  parameter int ITER = 32
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [1:0]  op,
  input  logic [31:0] rsdata,
  input  logic [31:0] rtdata,
  input  logic        mthi,
  input  logic        mtlo,
  input  logic [31:0] writedata,
  output logic        busy,
  output logic        done,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  localparam int CW = $clog2(ITER + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(ITER - 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIX  = 2'd2
  } state_t;

  state_t        state_r;
  logic [CW-1:0] cnt_r;
  logic          is_div_r;
  logic          neg_q_r;
  logic          neg_rem_r;
  logic          dz_r;
  logic [31:0]   opnd_r;
  logic [63:0]   acc_r;
  logic          busy_r;
  logic          done_r;
  logic [31:0]   hi_r;
  logic [31:0]   lo_r;

  logic          a_neg_s;
  logic          b_neg_s;
  logic [31:0]   a_abs_s;
  logic [31:0]   b_abs_s;
  logic [32:0]   mul_sum_s;
  logic [63:0]   mul_next_s;
  logic          div_ge_s;
  logic [31:0]   div_diff_s;
  logic [63:0]   div_next_s;
  logic [63:0]   prod_s;
  logic [31:0]   quot_s;
  logic [31:0]   rem_s;

  // Operand magnitudes and signs; only signed ops (op[0]) see negative inputs.
  always_comb begin
    a_neg_s = op[0] & rsdata[31];
    b_neg_s = op[0] & rtdata[31];
    a_abs_s = a_neg_s ? (32'd0 - rsdata) : rsdata;
    b_abs_s = b_neg_s ? (32'd0 - rtdata) : rtdata;
  end

  // One iteration step of each algorithm plus the signed fix-up of the final result.
  always_comb begin
    // Multiply: multiplier sits in acc low half and shifts out as partial sums shift in.
    mul_sum_s  = {1'b0, acc_r[63:32]} + (acc_r[0] ? {1'b0, opnd_r} : 33'd0);
    mul_next_s = {mul_sum_s, acc_r[31:1]};
    // Divide: remainder in the high half, dividend bits shift up into it, quotient bits fill the low end.
    div_ge_s   = acc_r[63:31] >= {1'b0, opnd_r};
    div_diff_s = acc_r[62:31] - opnd_r;
    div_next_s = div_ge_s ? {div_diff_s, acc_r[30:0], 1'b1} : {acc_r[62:0], 1'b0};
    prod_s     = neg_q_r ? (64'd0 - acc_r) : acc_r;
    quot_s     = dz_r ? 32'hFFFF_FFFF : (neg_q_r ? (32'd0 - acc_r[31:0]) : acc_r[31:0]);
    rem_s      = neg_rem_r ? (32'd0 - acc_r[63:32]) : acc_r[63:32];
  end

  // Control FSM, iteration datapath and HI/LO architectural registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r   <= IDLE;
      cnt_r     <= {CW{1'b0}};
      is_div_r  <= 1'b0;
      neg_q_r   <= 1'b0;
      neg_rem_r <= 1'b0;
      dz_r      <= 1'b0;
      opnd_r    <= 32'd0;
      acc_r     <= 64'd0;
      busy_r    <= 1'b0;
      done_r    <= 1'b0;
      hi_r      <= 32'd0;
      lo_r      <= 32'd0;
    end else begin
      case (state_r)
        IDLE: begin
          done_r <= 1'b0;
          if (start) begin
            state_r   <= RUN;
            busy_r    <= 1'b1;
            cnt_r     <= {CW{1'b0}};
            is_div_r  <= op[1];
            neg_q_r   <= a_neg_s ^ b_neg_s;
            neg_rem_r <= op[1] & a_neg_s;
            dz_r      <= op[1] & (rtdata == 32'd0);
            opnd_r    <= op[1] ? b_abs_s : a_abs_s;
            acc_r     <= {32'd0, (op[1] ? a_abs_s : b_abs_s)};
          end else begin
            if (mthi) begin
              hi_r <= writedata;
            end
            if (mtlo) begin
              lo_r <= writedata;
            end
          end
        end
        RUN: begin
          acc_r <= is_div_r ? div_next_s : mul_next_s;
          if (cnt_r == CNT_LAST) begin
            state_r <= FIX;
          end else begin
            cnt_r <= cnt_r + CNT_ONE;
          end
        end
        FIX: begin
          if (is_div_r) begin
            hi_r <= rem_s;
            lo_r <= quot_s;
          end else begin
            hi_r <= prod_s[63:32];
            lo_r <= prod_s[31:0];
          end
          state_r <= IDLE;
          busy_r  <= 1'b0;
          done_r  <= 1'b1;
        end
        default: begin
          state_r <= IDLE;
          busy_r  <= 1'b0;
          done_r  <= 1'b0;
        end
      endcase
    end
  end

  assign busy = busy_r;
  assign done = done_r;
  assign hi   = hi_r;
  assign lo   = lo_r;

endmodule

// File: tb/tb_mult_div_unit.sv
// Self-checking bench for mult_div_unit: directed vector table, corner sequences,
// and randomized operations against an arithmetic reference model.
module tb_mult_div_unit;

  localparam int ITER = 32;

  logic        clk_s = 1'b0;
  logic        rst_n_s;
  logic        start_s;
  logic [1:0]  op_s;
  logic [31:0] rs_s;
  logic [31:0] rt_s;
  logic        mthi_s;
  logic        mtlo_s;
  logic [31:0] wd_s;
  logic        busy_s;
  logic        done_s;
  logic [31:0] hi_s;
  logic [31:0] lo_s;

  int n_cmp = 0;
  int n_err = 0;

  typedef struct {
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] hi;
    logic [31:0] lo;
  } vec_t;

  vec_t vecs[10];

  mult_div_unit #(.ITER(ITER)) dut (
    .clk(clk_s), .rst_n(rst_n_s), .start(start_s), .op(op_s),
    .rsdata(rs_s), .rtdata(rt_s), .mthi(mthi_s), .mtlo(mtlo_s),
    .writedata(wd_s), .busy(busy_s), .done(done_s), .hi(hi_s), .lo(lo_s)
  );

  always #5 clk_s = ~clk_s;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk_s);
    #1;
  endtask

  // Reference: plain integer arithmetic; division truncates toward zero.
  function automatic logic [63:0] model(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb, q, r;
    logic [63:0] res;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    case (op)
      2'b00: res = {32'd0, a} * {32'd0, b};
      2'b01: res = sa * sb;
      2'b10: res = (b == 32'd0) ? {a, 32'hFFFF_FFFF} : {a % b, a / b};
      default: begin
        if (b == 32'd0) begin
          res = {a, 32'hFFFF_FFFF};
        end else begin
          q = sa / sb;
          r = sa % sb;
          res = {r[31:0], q[31:0]};
        end
      end
    endcase
    return res;
  endfunction

  // Issue an op at the next edge (N) and check busy/done/hold timing and the result.
  // Returns #1 after edge N+ITER+1, in the cycle where done is high.
  task automatic do_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [63:0] exp, input bit disturb, input string name);
    logic        bad;
    logic [31:0] prev_hi;
    logic [31:0] prev_lo;
    bad = 1'b0;
    prev_hi = hi_s;
    prev_lo = lo_s;
    op_s = op; rs_s = a; rt_s = b; start_s = 1'b1;
    step();
    start_s = 1'b0; mthi_s = 1'b0; mtlo_s = 1'b0;
    rs_s = $urandom; rt_s = $urandom;
    for (int k = 0; k <= ITER; k++) begin
      if (busy_s !== 1'b1 || done_s !== 1'b0 || hi_s !== prev_hi || lo_s !== prev_lo) bad = 1'b1;
      if (disturb && k == 5) begin
        start_s = 1'b1; op_s = 2'b10; mtlo_s = 1'b1; wd_s = 32'hDEAD_BEEF;
      end else if (disturb && k == 6) begin
        start_s = 1'b0; mtlo_s = 1'b0;
      end
      if (k < ITER) step();
    end
    chk({name, " busy_window"}, {63'd0, bad}, 64'd0);
    step();
    chk({name, " done"}, {63'd0, done_s}, 64'd1);
    chk({name, " busy_end"}, {63'd0, busy_s}, 64'd0);
    chk({name, " hi"}, {32'd0, hi_s}, {32'd0, exp[63:32]});
    chk({name, " lo"}, {32'd0, lo_s}, {32'd0, exp[31:0]});
  endtask

  initial begin
    logic        bad;
    logic [1:0]  rop;
    logic [31:0] ra, rb;
    logic [31:0] save_lo;

    vecs[0] = '{2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001};
    vecs[1] = '{2'b01, 32'hFFFF_FFFD, 32'h0000_0005, 32'hFFFF_FFFF, 32'hFFFF_FFF1};
    vecs[2] = '{2'b11, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 32'hFFFF_FFFD};
    vecs[3] = '{2'b10, 32'h0000_0005, 32'h0000_0000, 32'h0000_0005, 32'hFFFF_FFFF};
    vecs[4] = '{2'b11, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000};
    vecs[5] = '{2'b00, 32'h0000_0002, 32'h0000_0003, 32'h0000_0000, 32'h0000_0006};
    vecs[6] = '{2'b10, 32'h0000_0064, 32'h0000_0007, 32'h0000_0002, 32'h0000_000E};
    vecs[7] = '{2'b11, 32'h0000_0007, 32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFD};
    vecs[8] = '{2'b11, 32'hFFFF_FFF9, 32'h0000_0000, 32'hFFFF_FFF9, 32'hFFFF_FFFF};
    vecs[9] = '{2'b01, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000};

    rst_n_s = 1'b0; start_s = 1'b0; op_s = 2'b00; rs_s = 32'd0; rt_s = 32'd0;
    mthi_s = 1'b0; mtlo_s = 1'b0; wd_s = 32'd0;
    repeat (3) step();
    chk("reset busy", {63'd0, busy_s}, 64'd0);
    chk("reset done", {63'd0, done_s}, 64'd0);
    chk("reset hi", {32'd0, hi_s}, 64'd0);
    chk("reset lo", {32'd0, lo_s}, 64'd0);

    // Release reset; the first op starts on the very next edge, and the table runs back-to-back.
    rst_n_s = 1'b1;
    for (int i = 0; i < 10; i++) begin
      do_op(vecs[i].op, vecs[i].a, vecs[i].b, {vecs[i].hi, vecs[i].lo}, 1'b0, $sformatf("vec%0d", i));
    end
    step();
    chk("done pulse width", {63'd0, done_s}, 64'd0);

    // Direct HI/LO writes in idle.
    save_lo = lo_s;
    wd_s = 32'h1234_5678; mthi_s = 1'b1;
    step();
    mthi_s = 1'b0;
    chk("mthi hi", {32'd0, hi_s}, 64'h0000_0000_1234_5678);
    chk("mthi lo kept", {32'd0, lo_s}, {32'd0, save_lo});
    wd_s = 32'hABCD_0123; mtlo_s = 1'b1;
    step();
    mtlo_s = 1'b0;
    chk("mtlo lo", {32'd0, lo_s}, 64'h0000_0000_ABCD_0123);
    chk("mtlo hi kept", {32'd0, hi_s}, 64'h0000_0000_1234_5678);
    wd_s = 32'h5555_AAAA; mthi_s = 1'b1; mtlo_s = 1'b1;
    step();
    mthi_s = 1'b0; mtlo_s = 1'b0;
    chk("mthi+mtlo", {hi_s, lo_s}, 64'h5555_AAAA_5555_AAAA);

    // mthi coinciding with start, then mtlo plus a second start mid-operation: all ignored.
    wd_s = 32'h1111_1111; mthi_s = 1'b1;
    do_op(2'b00, 32'd7, 32'd6, 64'd42, 1'b1, "disturbed");
    bad = 1'b0;
    for (int k = 0; k < ITER + 4; k++) begin
      step();
      if (done_s !== 1'b0 || busy_s !== 1'b0 || lo_s !== 32'd42) bad = 1'b1;
    end
    chk("second start ignored", {63'd0, bad}, 64'd0);

    // Randomized back-to-back operations against the reference model.
    for (int i = 0; i < 30; i++) begin
      rop = 2'($urandom_range(0, 3));
      ra = ($urandom_range(0, 5) == 0) ? 32'h8000_0000 : 32'($urandom);
      case ($urandom_range(0, 4))
        0: rb = 32'd0;
        1: rb = 32'($urandom_range(1, 20));
        2: rb = 32'hFFFF_FFFF;
        default: rb = 32'($urandom);
      endcase
      do_op(rop, ra, rb, model(rop, ra, rb), 1'b0, $sformatf("rand%0d op%0d", i, rop));
    end
    step();

    // Reset ten cycles into a divide aborts it.
    wd_s = 32'hFFFF_FFFF; mthi_s = 1'b1; mtlo_s = 1'b1;
    step();
    mthi_s = 1'b0; mtlo_s = 1'b0;
    op_s = 2'b11; rs_s = 32'd1000; rt_s = 32'd7; start_s = 1'b1;
    step();
    start_s = 1'b0;
    repeat (9) step();
    #2 rst_n_s = 1'b0;
    #1;
    chk("abort busy", {63'd0, busy_s}, 64'd0);
    chk("abort done", {63'd0, done_s}, 64'd0);
    chk("abort hi/lo", {hi_s, lo_s}, 64'd0);
    step();
    step();
    rst_n_s = 1'b1;
    bad = 1'b0;
    for (int k = 0; k < ITER + 4; k++) begin
      step();
      if (done_s !== 1'b0 || busy_s !== 1'b0 || hi_s !== 32'd0 || lo_s !== 32'd0) bad = 1'b1;
    end
    chk("no done after abort", {63'd0, bad}, 64'd0);
    do_op(2'b00, 32'd2, 32'd3, 64'd6, 1'b0, "post-reset multu");
    step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
